cut_sequencer: RTL and testbench
================================

# cut_sequencer

Initiator side of the cut handshake: issues `cut_o` requests to the cut controller/driver, waits for its `cut_end_i` completion, and repeats for a programmed number of cuts with an enforced low gap between requests. Sits between the top-level job controller and the cut controller driver. It also counts completed cuts, raises a sticky fault when the driver fails to answer within a timeout, and supports abort.

## Interface
- `CNT_W`, 8, width of cut count and programmed cut number
- `GAP_CYCLES`, 10, minimum cycles `cut_o` stays low between consecutive cuts (≥1)
- `TIMEOUT_CYCLES`, 5000000, max cycles `cut_o` may be high without `cut_end_i` (≥2)
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `start_i`  in  1  start job; sampled only in IDLE or FAULT
- `num_cuts_i`  in  CNT_W  cuts in job; latched on accepted `start_i`
- `abort_i`  in  1  cancel job; highest priority after `rst`
- `cut_end_i`  in  1  completion level from cut driver
- `cut_o`  out  1  cut request to driver (registered)
- `busy_o`  out  1  high in CUT or GAP
- `done_o`  out  1  one-cycle pulse when all cuts completed
- `fault_o`  out  1  sticky timeout flag
- `cut_count_o`  out  CNT_W  cuts completed in current/last job

## Operation
- States: IDLE, CUT, GAP, FAULT. Single counter `tmr` (32 bit) shared for gap and timeout.
- Reset: state IDLE; `cut_o`=0, `busy_o`=0, `done_o`=0, `fault_o`=0, `cut_count_o`=0, `tmr`=0, latched count=0.
- IDLE: on `start_i`, latch `num_cuts_i`, clear `cut_count_o`. If latched value 0 → stay IDLE, pulse `done_o`. Else → CUT, `cut_o`=1, `tmr`=0.
- CUT: `tmr` increments each cycle. If `cut_end_i`=1: `cut_o`=0, `cut_count_o`+1; if new count equals latched number → IDLE with `done_o` pulse, else → GAP, `tmr`=0. Else if `tmr` = TIMEOUT_CYCLES−1 → FAULT, `cut_o`=0, `fault_o`=1.
- GAP: `cut_o`=0; `tmr` increments. Leave to CUT (`cut_o`=1, `tmr`=0) only when `tmr` ≥ GAP_CYCLES−1 and `cut_end_i`=0; otherwise hold (driver must drop `cut_end_i` before next request).
- FAULT: outputs frozen, `cut_o`=0, `busy_o`=0. `start_i` clears `fault_o` and behaves as in IDLE.
- `abort_i` in any state: next state IDLE, `cut_o`=0, no `done_o`, `fault_o` cleared, `cut_count_o` retained.
- `start_i` in CUT/GAP ignored. `cut_end_i` in IDLE/GAP/FAULT ignored except GAP exit condition.
- Count arithmetic modulo 2^CNT_W; `num_cuts_i`=2^CNT_W−1 is legal maximum.

## Timing
- `start_i` sampled at edge T → `cut_o`, `busy_o` high from T.
- `cut_end_i` high sampled at edge E → `cut_o` low and `cut_count_o` updated from E; `done_o` high for exactly the cycle after E (last cut).
- Next `cut_o` rise no earlier than E+GAP_CYCLES, and not before the edge after `cut_end_i` is sampled low.
- Timeout: `cut_o` high from T, no `cut_end_i` → `fault_o` high, `cut_o` low from edge T+TIMEOUT_CYCLES.
- `cut_end_i` on the same edge as timeout reached: completion wins, no fault.
- `abort_i` with `cut_end_i` same edge: abort wins, count not incremented.
- `rst` mid-job: all outputs at reset values next cycle; `rst` overrides `abort_i`/`start_i`.

## Test plan
- Reset then idle: `rst` 2 cycles → all outputs 0; `cut_end_i` toggling in IDLE changes nothing.
- 3-cut job, GAP_CYCLES=10: `start_i` with `num_cuts_i`=3, driver answers `cut_end_i` 50 cycles after each rise, drops it 2 cycles later → three `cut_o` pulses, low gaps exactly 10 cycles, `cut_count_o` 1,2,3, single `done_o` after third.
- Stuck `cut_end_i`: driver holds `cut_end_i` high 30 cycles after first cut → second `cut_o` rise waits until one cycle after it drops.
- Timeout with TIMEOUT_CYCLES=100: no `cut_end_i` → `fault_o`=1 and `cut_o`=0 exactly 100 cycles after rise; new `start_i` with 1 cut clears fault and completes.
- Abort mid-job: `num_cuts_i`=4, `abort_i` during second CUT → `cut_o` low next cycle, no `done_o`, `cut_count_o`=1, `busy_o`=0.
- Zero cuts and corner: `num_cuts_i`=0 → `done_o` pulse, `cut_o` never rises; `cut_end_i` on timeout edge → counted, no fault.

Source files
------------

// File: rtl/cut_sequencer.sv
// Cut request initiator: issues num_cuts cut requests, each held until the driver completes, with a minimum low gap between them.
// Latency: cut_o/busy_o rise on the edge that accepts start_i; cut_o falls and the count updates on the edge that samples cut_end_i.
// Backpressure: the next request waits for the gap to expire and for cut_end_i to drop; a silent driver trips a sticky timeout fault.
module cut_sequencer #(
  parameter int CNT_W          = 8,
  parameter int GAP_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_cuts_i,
  input  logic             abort_i,
  input  logic             cut_end_i,
  output logic             cut_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] cut_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CUT,
    ST_GAP,
    ST_FAULT
  } state_t;

  localparam logic [31:0]      GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [31:0]      tmr_q, tmr_d, tmr_inc;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic             cut_q, cut_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;

  // Saturate so a long-held cut_end_i in GAP can never wrap the timer.
  assign tmr_inc   = (tmr_q == 32'hFFFF_FFFF) ? tmr_q : tmr_q + 32'd1;
  assign count_inc = count_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    num_d   = num_q;
    count_d = count_q;
    cut_d   = cut_q;
    done_d  = 1'b0;
    fault_d = fault_q;

    if (abort_i) begin
      state_d = ST_IDLE;
      cut_d   = 1'b0;
      fault_d = 1'b0;
      tmr_d   = 32'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FAULT: begin
          if (start_i) begin
            fault_d = 1'b0;
            num_d   = num_cuts_i;
            count_d = '0;
            tmr_d   = 32'd0;
            if (num_cuts_i == '0) begin
              state_d = ST_IDLE;
              cut_d   = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = ST_CUT;
              cut_d   = 1'b1;
            end
          end
        end
        ST_CUT: begin
          // Completion beats a timeout reached on the same edge.
          if (cut_end_i) begin
            cut_d   = 1'b0;
            count_d = count_inc;
            tmr_d   = 32'd0;
            if (count_inc == num_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_GAP;
            end
          end else if (tmr_q == TO_LAST) begin
            state_d = ST_FAULT;
            cut_d   = 1'b0;
            fault_d = 1'b1;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        ST_GAP: begin
          cut_d = 1'b0;
          if (tmr_q >= GAP_LAST && !cut_end_i) begin
            state_d = ST_CUT;
            cut_d   = 1'b1;
            tmr_d   = 32'd0;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cut_d   = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == ST_CUT) || (state_d == ST_GAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= 32'd0;
      num_q   <= '0;
      count_q <= '0;
      cut_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      num_q   <= num_d;
      count_q <= count_d;
      cut_q   <= cut_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign cut_o       = cut_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign cut_count_o = count_q;

endmodule

// File: tb/tb_cut_sequencer.sv
// Directed bench for cut_sequencer: per-cycle vector table plus hand-written gap, stuck-completion, timeout and abort sequences.
module tb_cut_sequencer;

  localparam int CNT_W   = 8;
  localparam int GAP     = 10;
  localparam int TIMEOUT = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] num_cuts_i = '0;
  logic             abort_i = 1'b0;
  logic             cut_end_i = 1'b0;
  logic             cut_o, busy_o, done_o, fault_o;
  logic [CNT_W-1:0] cut_count_o;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  cut_sequencer #(.CNT_W(CNT_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_cuts_i(num_cuts_i),
    .abort_i(abort_i), .cut_end_i(cut_end_i), .cut_o(cut_o), .busy_o(busy_o),
    .done_o(done_o), .fault_o(fault_o), .cut_count_o(cut_count_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done_o === 1'b1) done_seen++;

  typedef struct {
    logic             r, s, a, e;
    logic [CNT_W-1:0] n;
    logic             cut, busy, done, fault;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, s, a, e, input logic [CNT_W-1:0] n,
                     input logic c, b, d, f, input logic [CNT_W-1:0] cn);
    vec_t v;
    v = '{r, s, a, e, n, c, b, d, f, cn};
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rise(input int budget, output int n);
    n = 0;
    while (cut_o !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int snap;

    //  rst s a e num   cut busy done fault cnt
    add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 0, 1, 0, 0);  // zero cuts: done only
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1,   1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 5,   1, 1, 0, 0, 0);  // start ignored in CUT
    add(0, 0, 0, 1, 0,   0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0,   0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 2,   1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0,   0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0,   0, 0, 0, 0, 1);  // abort in GAP
    add(0, 1, 0, 0, 2,   1, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0,   0, 0, 0, 0, 0);  // abort beats completion
    add(1, 1, 0, 0, 3,   0, 0, 0, 0, 0);  // rst beats start
    add(0, 1, 0, 0, 1,   1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].r; start_i = vq[i].s; abort_i = vq[i].a;
      cut_end_i = vq[i].e; num_cuts_i = vq[i].n;
      step();
      check($sformatf("vec%0d", i),
            32'({cut_o, busy_o, done_o, fault_o, cut_count_o}),
            32'({vq[i].cut, vq[i].busy, vq[i].done, vq[i].fault, vq[i].cnt}));
    end
    rst = 0; start_i = 0; abort_i = 0; cut_end_i = 0;
    step();

    // 3-cut job, completion 50 cycles after each rise, held 2 cycles.
    snap = done_seen;
    start_i = 1; num_cuts_i = 3;
    step();
    start_i = 0;
    check("job3_rise", 32'({cut_o, busy_o}), 32'b11);
    for (int k = 1; k <= 3; k++) begin
      repeat (49) step();
      check($sformatf("job3_high%0d", k), 32'(cut_o), 32'd1);
      cut_end_i = 1;
      step();
      check($sformatf("job3_cnt%0d", k), 32'({cut_o, done_o, cut_count_o}),
            32'({1'b0, (k == 3), 8'(k)}));
      step();
      cut_end_i = 0;
      check($sformatf("job3_busy%0d", k), 32'({cut_o, busy_o, done_o}),
            32'({1'b0, (k != 3), 1'b0}));
      if (k < 3) begin
        wait_rise(200, n);
        check($sformatf("job3_gap%0d", k), 32'(n + 1), 32'(GAP));
      end
    end
    check("job3_done_once", 32'(done_seen - snap), 32'd1);

    // Completion held high 30 cycles delays the second request.
    start_i = 1; num_cuts_i = 2;
    step();
    start_i = 0;
    repeat (49) step();
    cut_end_i = 1;
    step();
    repeat (29) step();
    check("stuck_hold", 32'({cut_o, busy_o, cut_count_o}), 32'({1'b0, 1'b1, 8'd1}));
    cut_end_i = 0;
    step();
    check("stuck_rise", 32'(cut_o), 32'd1);
    cut_end_i = 1;
    step();
    check("stuck_done", 32'({done_o, cut_count_o}), 32'({1'b1, 8'd2}));
    cut_end_i = 0;
    step();

    // Timeout, then recovery with a 1-cut job.
    start_i = 1; num_cuts_i = 1;
    step();
    start_i = 0;
    repeat (TIMEOUT - 1) step();
    check("to_before", 32'({cut_o, fault_o}), 32'b10);
    step();
    check("to_fault", 32'({cut_o, busy_o, fault_o}), 32'b001);
    repeat (3) step();
    check("to_sticky", 32'({cut_o, fault_o, done_o}), 32'b010);
    start_i = 1; num_cuts_i = 1;
    step();
    start_i = 0;
    check("to_restart", 32'({cut_o, busy_o, fault_o, cut_count_o}), 32'({3'b110, 8'd0}));
    cut_end_i = 1;
    step();
    cut_end_i = 0;
    check("to_complete", 32'({done_o, fault_o, cut_count_o}), 32'({2'b10, 8'd1}));
    step();

    // Abort during the second cut of a 4-cut job.
    snap = done_seen;
    start_i = 1; num_cuts_i = 4;
    step();
    start_i = 0;
    repeat (49) step();
    cut_end_i = 1;
    step();
    cut_end_i = 0;
    step();
    wait_rise(200, n);
    check("abort_second_rise", 32'(cut_o), 32'd1);
    repeat (5) step();
    abort_i = 1;
    step();
    abort_i = 0;
    check("abort_out", 32'({cut_o, busy_o, done_o, fault_o, cut_count_o}), 32'({4'b0000, 8'd1}));
    repeat (20) step();
    check("abort_quiet", 32'({cut_o, done_seen - snap}), 32'd0);

    // Completion on the very edge the timeout would fire.
    start_i = 1; num_cuts_i = 1;
    step();
    start_i = 0;
    repeat (TIMEOUT - 1) step();
    cut_end_i = 1;
    step();
    cut_end_i = 0;
    check("edge_win", 32'({cut_o, done_o, fault_o, cut_count_o}), 32'({3'b010, 8'd1}));
    step();
    check("edge_after", 32'({fault_o, busy_o}), 32'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
